// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: IF/ID/EX/MEM/WB sequencer for the multicycle RV32I core.
// Define MCU_PERF_CNT_EN to build the cycle_count / instret performance counters.
module multicycle_control_unit #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             alu_bcond,
    input  logic             is_halt_val,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op_sel,
    output logic             halted,
    output logic             error,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_INIT  = 4'd0,
        S_IF    = 4'd1,
        S_ID    = 4'd2,
        S_EX    = 4'd3,
        S_MEM   = 4'd4,
        S_WB    = 4'd5,
        S_ECALL = 4'd6,
        S_HALT  = 4'd7
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_ARITHI = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_FUNCT  = 2'b01;
    localparam logic [1:0] ALU_BRANCH = 2'b10;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] WB_ALUOUT  = 2'b00;
    localparam logic [1:0] WB_MDR     = 2'b01;
    localparam logic [1:0] WB_PC      = 2'b10;

    // Wait counter only needs to reach MEM_TIMEOUT-1: the last allowed cycle.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t            state_reg, state_next;
    logic              error_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              timeout_hit;
    logic              timeout_fire;
    logic              is_load;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_reg == WAIT_LAST);
    assign is_load     = (opcode == OP_LOAD);

    always_comb begin
        state_next   = state_reg;
        timeout_fire = 1'b0;
        pc_write     = 1'b0;
        pc_source    = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = WB_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_B;
        alu_op_sel   = ALU_ADD;
        case (state_reg)
            S_INIT: state_next = S_IF;
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_ID;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    state_next   = S_HALT;
                end
            end
            S_ID: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_IMM;
                state_next = (opcode == OP_SYSTEM) ? S_ECALL : S_EX;
            end
            S_EX: begin
                state_next = S_IF;
                case (opcode)
                    OP_ARITH: begin
                        alu_src_a  = SRCA_A;
                        alu_src_b  = SRCB_B;
                        alu_op_sel = ALU_FUNCT;
                        state_next = S_WB;
                    end
                    OP_ARITHI: begin
                        alu_src_a  = SRCA_A;
                        alu_src_b  = SRCB_IMM;
                        alu_op_sel = ALU_FUNCT;
                        state_next = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a  = SRCA_A;
                        alu_src_b  = SRCB_IMM;
                        state_next = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a  = SRCA_A;
                        alu_src_b  = SRCB_B;
                        alu_op_sel = ALU_BRANCH;
                        pc_write   = alu_bcond;
                        pc_source  = 1'b1;
                    end
                    // ALUOut already holds old_pc+imm from ID; PC already holds the link value.
                    OP_JAL: begin
                        pc_write  = 1'b1;
                        pc_source = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC;
                    end
                    OP_JALR: begin
                        alu_src_a = SRCA_A;
                        alu_src_b = SRCB_IMM;
                        pc_write  = 1'b1;
                        pc_source = 1'b0;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC;
                    end
                    default: state_next = S_IF;
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = is_load;
                mem_write = !is_load;
                if (mem_ready) begin
                    state_next = is_load ? S_WB : S_IF;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    state_next   = S_HALT;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                wb_sel     = is_load ? WB_MDR : WB_ALUOUT;
                state_next = S_IF;
            end
            S_ECALL: state_next = is_halt_val ? S_HALT : S_IF;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_INIT;
            error_reg    <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (timeout_fire) begin
                error_reg <= 1'b1;
            end
            if (state_next != state_reg) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == S_IF || state_reg == S_MEM) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
        end
    end

    assign state  = state_reg;
    assign halted = (state_reg == S_HALT);
    assign error  = error_reg;

`ifdef MCU_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_count_reg;
    logic [CNT_W-1:0] instret_reg;
    logic             retire;

    assign retire = (state_next == S_IF) &&
                    (state_reg == S_EX || state_reg == S_MEM ||
                     state_reg == S_WB || state_reg == S_ECALL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count_reg <= '0;
            instret_reg     <= '0;
        end else begin
            if (state_reg != S_INIT && state_reg != S_HALT) begin
                cycle_count_reg <= cycle_count_reg + 1'b1;
            end
            if (retire) begin
                instret_reg <= instret_reg + 1'b1;
            end
        end
    end

    assign cycle_count = cycle_count_reg;
    assign instret     = instret_reg;
`else
    assign cycle_count = '0;
    assign instret     = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected state/controls via a scoreboard queue.
// A second instance with MEM_TIMEOUT=4 exercises the memory timeout path.
module tb_multicycle_control_unit;

`ifdef MCU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic        clk = 1'b0;
    logic        reset_n, reset_n_t;
    logic [6:0]  opcode;
    logic        alu_bcond, is_halt_val, mem_ready, mem_ready_t;
    logic [6:0]  opcode_t = OP_R;
    logic        alu_bcond_t = 1'b0;
    logic        is_halt_val_t = 1'b0;

    logic        pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write, halted, error;
    logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op_sel;
    logic [3:0]  state;
    logic [31:0] cycle_count, instret;

    logic        pc_write_t, pc_source_t, i_or_d_t, mem_read_t, mem_write_t, ir_write_t, reg_write_t;
    logic        halted_t, error_t;
    logic [1:0]  wb_sel_t, alu_src_a_t, alu_src_b_t, alu_op_sel_t;
    logic [3:0]  state_t;
    logic [31:0] cycle_count_t, instret_t;

    always #5 clk = ~clk;

    multicycle_control_unit #(.CNT_W(32), .MEM_TIMEOUT(0)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_bcond(alu_bcond),
        .is_halt_val(is_halt_val), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
        .halted(halted), .error(error), .state(state),
        .cycle_count(cycle_count), .instret(instret)
    );

    multicycle_control_unit #(.CNT_W(32), .MEM_TIMEOUT(4)) dut_to (
        .clk(clk), .reset_n(reset_n_t), .opcode(opcode_t), .alu_bcond(alu_bcond_t),
        .is_halt_val(is_halt_val_t), .mem_ready(mem_ready_t),
        .pc_write(pc_write_t), .pc_source(pc_source_t), .i_or_d(i_or_d_t), .mem_read(mem_read_t),
        .mem_write(mem_write_t), .ir_write(ir_write_t), .reg_write(reg_write_t), .wb_sel(wb_sel_t),
        .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t), .alu_op_sel(alu_op_sel_t),
        .halted(halted_t), .error(error_t), .state(state_t),
        .cycle_count(cycle_count_t), .instret(instret_t)
    );

    wire [16:0] ctrl   = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
                          wb_sel, alu_src_a, alu_src_b, alu_op_sel, halted, error};
    wire [16:0] ctrl_t = {pc_write_t, pc_source_t, i_or_d_t, mem_read_t, mem_write_t, ir_write_t,
                          reg_write_t, wb_sel_t, alu_src_a_t, alu_src_b_t, alu_op_sel_t, halted_t, error_t};

    function automatic logic [16:0] cv(input logic pcw, input logic pcs, input logic iod,
                                       input logic mr, input logic mw, input logic irw, input logic rw,
                                       input logic [1:0] wb, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] op, input logic hl, input logic er);
        return {pcw, pcs, iod, mr, mw, irw, rw, wb, sa, sb, op, hl, er};
    endfunction

    //                           pcw pcs iod mr mw irw rw  wb    sa    sb    op    hl er
    wire [16:0] C_IDLE    = cv(0,  0,  0,  0, 0, 0,  0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
    wire [16:0] C_IFW     = cv(0,  0,  0,  1, 0, 0,  0, 2'd0, 2'd0, 2'd1, 2'd0, 0, 0);
    wire [16:0] C_IFR     = cv(1,  0,  0,  1, 0, 1,  0, 2'd0, 2'd0, 2'd1, 2'd0, 0, 0);
    wire [16:0] C_ID      = cv(0,  0,  0,  0, 0, 0,  0, 2'd0, 2'd1, 2'd2, 2'd0, 0, 0);
    wire [16:0] C_EX_R    = cv(0,  0,  0,  0, 0, 0,  0, 2'd0, 2'd2, 2'd0, 2'd1, 0, 0);
    wire [16:0] C_EX_LS   = cv(0,  0,  0,  0, 0, 0,  0, 2'd0, 2'd2, 2'd2, 2'd0, 0, 0);
    wire [16:0] C_EX_BT   = cv(1,  1,  0,  0, 0, 0,  0, 2'd0, 2'd2, 2'd0, 2'd2, 0, 0);
    wire [16:0] C_EX_BN   = cv(0,  1,  0,  0, 0, 0,  0, 2'd0, 2'd2, 2'd0, 2'd2, 0, 0);
    wire [16:0] C_EX_JAL  = cv(1,  1,  0,  0, 0, 0,  1, 2'd2, 2'd0, 2'd0, 2'd0, 0, 0);
    wire [16:0] C_EX_JALR = cv(1,  0,  0,  0, 0, 0,  1, 2'd2, 2'd2, 2'd2, 2'd0, 0, 0);
    wire [16:0] C_MEM_LD  = cv(0,  0,  1,  1, 0, 0,  0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
    wire [16:0] C_MEM_ST  = cv(0,  0,  1,  0, 1, 0,  0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
    wire [16:0] C_WB_LD   = cv(0,  0,  0,  0, 0, 0,  1, 2'd1, 2'd0, 2'd0, 2'd0, 0, 0);
    wire [16:0] C_WB_R    = cv(0,  0,  0,  0, 0, 0,  1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
    wire [16:0] C_HALT    = cv(0,  0,  0,  0, 0, 0,  0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0);
    wire [16:0] C_HALTERR = cv(0,  0,  0,  0, 0, 0,  0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 1);

    typedef struct {
        string       tag;
        bit          to;
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    int   nerr = 0;
    int   nchecks = 0;
    int   exp_cyc = 0;
    int   exp_ret = 0;
    logic [3:0] prev_st = 4'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_cyc = 0;
        exp_ret = 0;
        prev_st = 4'd0;
    endtask

    // Push this cycle's expectation, sample mid-cycle, pop and compare, advance to posedge+1.
    task automatic step(input string tag, input bit to, input logic [3:0] st, input logic [16:0] c);
        exp_t e;
        exp_t got;
        e.tag = tag; e.to = to; e.st = st; e.ctrl = c; e.cyc = 32'd0; e.ret = 32'd0;
        if (!to) begin
            if (prev_st != 4'd0 && prev_st != 4'd7) exp_cyc++;
            if (st == 4'd1 && (prev_st >= 4'd3 && prev_st <= 4'd6)) exp_ret++;
            prev_st = st;
            if (PERF) begin
                e.cyc = 32'(exp_cyc);
                e.ret = 32'(exp_ret);
            end
        end
        sb.push_back(e);
        #4;
        got = sb.pop_front();
        if (got.to) begin
            chk({got.tag, ".state"}, {28'd0, state_t}, {28'd0, got.st});
            chk({got.tag, ".ctrl"},  {15'd0, ctrl_t}, {15'd0, got.ctrl});
        end else begin
            chk({got.tag, ".state"}, {28'd0, state}, {28'd0, got.st});
            chk({got.tag, ".ctrl"},  {15'd0, ctrl}, {15'd0, got.ctrl});
            chk({got.tag, ".cycle_count"}, cycle_count, got.cyc);
            chk({got.tag, ".instret"}, instret, got.ret);
        end
        $display("step %-10s to=%0d state=%0d ctrl=%05h cyc=%0d ret=%0d", got.tag, got.to,
                 got.to ? state_t : state, got.to ? ctrl_t : ctrl, cycle_count, instret);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; reset_n_t = 1'b0;
        opcode = OP_R; alu_bcond = 1'b0; is_halt_val = 1'b0;
        mem_ready = 1'b1; mem_ready_t = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("rst", 0, 4'd0, C_IDLE);
        reset_n = 1'b1;

        // ADD with memory always ready
        step("add.init", 0, 4'd0, C_IDLE);
        step("add.if",   0, 4'd1, C_IFR);
        step("add.id",   0, 4'd2, C_ID);
        step("add.ex",   0, 4'd3, C_EX_R);
        step("add.wb",   0, 4'd5, C_WB_R);

        // LW with wait states in IF and MEM
        opcode = OP_LOAD; mem_ready = 1'b0;
        step("lw.ifw1", 0, 4'd1, C_IFW);
        step("lw.ifw2", 0, 4'd1, C_IFW);
        step("lw.ifw3", 0, 4'd1, C_IFW);
        mem_ready = 1'b1;
        step("lw.ifr",  0, 4'd1, C_IFR);
        mem_ready = 1'b0;
        step("lw.id",   0, 4'd2, C_ID);
        step("lw.ex",   0, 4'd3, C_EX_LS);
        step("lw.memw1", 0, 4'd4, C_MEM_LD);
        step("lw.memw2", 0, 4'd4, C_MEM_LD);
        mem_ready = 1'b1;
        step("lw.memr", 0, 4'd4, C_MEM_LD);
        mem_ready = 1'b0;
        step("lw.wb",   0, 4'd5, C_WB_LD);
        mem_ready = 1'b1;

        // BEQ taken then not taken
        opcode = OP_BRANCH; alu_bcond = 1'b1;
        step("bt.if", 0, 4'd1, C_IFR);
        step("bt.id", 0, 4'd2, C_ID);
        step("bt.ex", 0, 4'd3, C_EX_BT);
        alu_bcond = 1'b0;
        step("bn.if", 0, 4'd1, C_IFR);
        step("bn.id", 0, 4'd2, C_ID);
        step("bn.ex", 0, 4'd3, C_EX_BN);

        // SW, JAL, JALR, unknown opcode
        opcode = OP_STORE;
        step("sw.if",  0, 4'd1, C_IFR);
        step("sw.id",  0, 4'd2, C_ID);
        step("sw.ex",  0, 4'd3, C_EX_LS);
        step("sw.mem", 0, 4'd4, C_MEM_ST);
        opcode = OP_JAL;
        step("jal.if", 0, 4'd1, C_IFR);
        step("jal.id", 0, 4'd2, C_ID);
        step("jal.ex", 0, 4'd3, C_EX_JAL);
        opcode = OP_JALR;
        step("jalr.if", 0, 4'd1, C_IFR);
        step("jalr.id", 0, 4'd2, C_ID);
        step("jalr.ex", 0, 4'd3, C_EX_JALR);
        opcode = OP_LUI;
        step("nop.if", 0, 4'd1, C_IFR);
        step("nop.id", 0, 4'd2, C_ID);
        step("nop.ex", 0, 4'd3, C_IDLE);

        // ECALL without and with halt
        opcode = OP_SYSTEM; is_halt_val = 1'b0;
        step("ec0.if", 0, 4'd1, C_IFR);
        step("ec0.id", 0, 4'd2, C_ID);
        step("ec0.ec", 0, 4'd6, C_IDLE);
        is_halt_val = 1'b1;
        step("ec1.if", 0, 4'd1, C_IFR);
        step("ec1.id", 0, 4'd2, C_ID);
        step("ec1.ec", 0, 4'd6, C_IDLE);
        is_halt_val = 1'b0;
        step("halt1",  0, 4'd7, C_HALT);
        step("halt2",  0, 4'd7, C_HALT);
        step("halt3",  0, 4'd7, C_HALT);

        // Reset out of HALT, then reset asynchronously in the middle of a store wait
        reset_n = 1'b0;
        #1;
        model_reset();
        step("hrst", 0, 4'd0, C_IDLE);
        reset_n = 1'b1;
        opcode = OP_STORE;
        step("rs.init", 0, 4'd0, C_IDLE);
        step("rs.if",   0, 4'd1, C_IFR);
        step("rs.id",   0, 4'd2, C_ID);
        mem_ready = 1'b0;
        step("rs.ex",   0, 4'd3, C_EX_LS);
        step("rs.mem",  0, 4'd4, C_MEM_ST);
        chk("rs.mw_pre", {31'd0, mem_write}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs.mw_async", {31'd0, mem_write}, 32'd0);
        chk("rs.state_async", {28'd0, state}, 32'd0);
        chk("rs.cyc_async", cycle_count, 32'd0);
        chk("rs.ret_async", instret, 32'd0);
        $display("async reset: state=%0d mem_write=%0d cyc=%0d ret=%0d", state, mem_write, cycle_count, instret);
        @(posedge clk);
        #1;
        model_reset();
        reset_n = 1'b1;
        mem_ready = 1'b1;
        step("ar.init", 0, 4'd0, C_IDLE);
        step("ar.if",   0, 4'd1, C_IFR);

        // Timeout instance: never ready -> HALT with error after 4 IF cycles
        reset_n_t = 1'b1;
        mem_ready_t = 1'b0;
        step("to.init", 1, 4'd0, C_IDLE);
        step("to.if1",  1, 4'd1, C_IFW);
        step("to.if2",  1, 4'd1, C_IFW);
        step("to.if3",  1, 4'd1, C_IFW);
        step("to.if4",  1, 4'd1, C_IFW);
        step("to.halt", 1, 4'd7, C_HALTERR);
        step("to.hold", 1, 4'd7, C_HALTERR);
        reset_n_t = 1'b0;
        #1;
        step("to.rst",  1, 4'd0, C_IDLE);
        reset_n_t = 1'b1;

        // Ready on the last allowed cycle is accepted without error
        step("tl.init", 1, 4'd0, C_IDLE);
        step("tl.if1",  1, 4'd1, C_IFW);
        step("tl.if2",  1, 4'd1, C_IFW);
        step("tl.if3",  1, 4'd1, C_IFW);
        mem_ready_t = 1'b1;
        step("tl.if4",  1, 4'd1, C_IFR);
        step("tl.id",   1, 4'd2, C_ID);
        step("tl.ex",   1, 4'd3, C_EX_R);
        step("tl.wb",   1, 4'd5, C_WB_R);
        step("tl.if",   1, 4'd1, C_IFR);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
